async_fifo_wr_arb: RTL
======================

Name: async_fifo_wr_arb

Overview:
- Write-domain controller and arbiter for the async FIFO.
- Shares the single FIFO write port among NUM_REQ requesters using round-robin arbitration.
- Owns the binary and Gray write pointers and produces write enable, address and data for the dual-port RAM.
- Computes w_Full and w_AlmostFull from the read pointer synchronised into the write clock domain.

Parameters:
- address_Size, 5, FIFO address width; depth = 2**address_Size.
- NUM_REQ, 4, number of write requesters (>=2).
- DATA_WIDTH, 8, payload width.
- AFULL_THRESH, 4, almost-full margin in entries (1..2**address_Size-1).

Ports:
- w_Clk  in  1  write-domain clock.
- w_Rst  in  1  reset; synchronous to w_Clk, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- wsync_Rptr  in  address_Size+1  Gray read pointer, already synchronised to w_Clk.
- w_En  out  1  RAM write enable.
- w_Addr  out  address_Size  RAM write address.
- w_Data  out  DATA_WIDTH  RAM write data.
- w_Ptr  out  address_Size+1  Gray write pointer, registered, for the w2r synchroniser.
- w_Full  out  1  FIFO full, registered.
- w_AlmostFull  out  1  occupancy >= 2**address_Size - AFULL_THRESH, registered.
- grant_id  out  clog2(NUM_REQ)  index of the current grant; valid when w_En=1.

Behaviour:
- Registered state: wbin (address_Size+1), w_Ptr, rr_ptr, w_Full, w_AlmostFull.
- Reset: while w_Rst=1 at a posedge, all registered state clears to 0. req_ready is forced to 0 while w_Rst=1, so w_En=0 during reset.
- Arbitration (combinational):
  - If w_Full=0, w_Rst=0 and any req_valid is set, grant the first set bit searching from rr_ptr upward, wrapping at NUM_REQ.
  - req_ready is one-hot on the granted index; all zero otherwise.
  - The grant depends only on registered state and req_valid, so there is no combinational loop.
- Write path (zero latency):
  - w_En = OR of (req_valid & req_ready).
  - w_Addr = wbin[address_Size-1:0].
  - w_Data = req_data slice of the granted requester.
- On a posedge with w_En=1:
  - wbin <= wbin+1, wrapping modulo 2**(address_Size+1).
  - w_Ptr <= bin2gray(wbin+1).
  - rr_ptr <= grant_id+1 mod NUM_REQ.
- Without w_En, wbin, w_Ptr and rr_ptr hold.
- Full: w_Full <= (gray(wbin_next) == {~wsync_Rptr[A:A-1], wsync_Rptr[A-2:0]}), where A = address_Size and wbin_next includes the current write.
- Almost full:
  - count_next = wbin_next - gray2bin(wsync_Rptr), computed modulo 2**(A+1).
  - w_AlmostFull <= (count_next >= 2**A - AFULL_THRESH).
- Full pessimism: w_Full deasserts only after a read-pointer update arrives through wsync_Rptr. A write in the cycle w_Full=1 is impossible.
- Simultaneous write and rptr advance: both are used in the same cycle's flag computation. A write on the last free slot together with a rptr advance of 1 leaves w_Full=0.
- Requester fairness: a requester holding req_valid is granted within NUM_REQ transfers.
- Requester contract: req_valid drops without a transfer are permitted; the arbiter holds no lock.
- Reset mid-operation: the next cycle sees wbin=0, w_Ptr=0 and rr_ptr=0. Pending requests are re-arbitrated from requester 0.

Decomposition:
- Package async_fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width;
  - the default address_Size constant;
  - the localparam GW = clog2(NUM_REQ) helper.
- Sub-module rr_arbiter (req, rr_ptr -> one-hot grant, grant_id) is combinational and instantiated once. The pointer/flag logic stays in the top.

Test Plan:
- Reset: w_Rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, w_En=0, w_Ptr=0, w_Full=0, w_AlmostFull=0.
- Fill: only req_valid[0]=1, wsync_Rptr=0, 32 cycles -> w_Addr 0..31 with data in order.
  - After the 32nd edge: w_Full=1, w_Ptr=6'b110000, req_ready=0.
  - The 33rd cycle gives w_En=0.
- Round-robin: req_valid=4'b1111 held, 6 cycles -> grant_id sequence 0,1,2,3,0,1; each w_Data equals the granted slice.
- Unfreeze: from full, set wsync_Rptr=6'b000001 -> w_Full=0 next edge. One write goes to w_Addr=0, then w_Full=1 again.
- Almost full (AFULL_THRESH=4): 28 writes with wsync_Rptr=0 -> w_AlmostFull=1 after the 28th edge and 0 after 27.
- Mid-reset: 10 writes, then w_Rst=1 for one edge -> wbin=0, w_Ptr=0. The next grant goes to requester 0 with w_Addr=0.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module : async_fifo_pkg
// Brief  : Shared constants and Gray-code helpers for the async FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

   localparam int ADDR_SIZE_DEF = 5;
   localparam int NUM_REQ_DEF   = 4;

   // Width of a requester index; never narrower than one bit.
   function automatic int gw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int GW = gw_of(NUM_REQ_DEF);

   function automatic logic [31:0] bin2gray(input logic [31:0] b, input int width);
      logic [31:0] v;
      v = b & ((32'd1 << width) - 32'd1);
      return v ^ (v >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
      logic [31:0] v;
      logic [31:0] b;
      v     = g & ((32'd1 << width) - 32'd1);
      b     = '0;
      b[31] = v[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ v[i];
      end
      return b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter, search starts at rr_ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int GW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   input  logic [GW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [GW-1:0]      grant_id
);

   always_comb begin
      logic w_found;
      int   w_idx;
      grant    = '0;
      grant_id = '0;
      w_found  = 1'b0;
      w_idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (en && !w_found && req[w_idx]) begin
            w_found      = 1'b1;
            grant[w_idx] = 1'b1;
            grant_id     = GW'(w_idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/async_fifo_wr_arb.sv
// ============================================================================
// Module : async_fifo_wr_arb
// Brief  : Async FIFO write-domain pointer/flag logic with round-robin writers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module async_fifo_wr_arb
   import async_fifo_pkg::*;
#(
   parameter int address_Size = ADDR_SIZE_DEF,
   parameter int NUM_REQ      = NUM_REQ_DEF,
   parameter int DATA_WIDTH   = 8,
   parameter int AFULL_THRESH = 4
) (
   input  logic                          w_Clk,
   input  logic                          w_Rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [address_Size:0]         wsync_Rptr,
   output logic                          w_En,
   output logic [address_Size-1:0]       w_Addr,
   output logic [DATA_WIDTH-1:0]         w_Data,
   output logic [address_Size:0]         w_Ptr,
   output logic                          w_Full,
   output logic                          w_AlmostFull,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

   localparam int              A          = address_Size;
   localparam int              c_GW       = gw_of(NUM_REQ);
   localparam logic [A:0]      c_AFULL_LVL = (A+1)'((1 << A) - AFULL_THRESH);
   localparam logic [c_GW-1:0] c_LAST_REQ = c_GW'(NUM_REQ - 1);

   logic [A:0]      r_wbin;
   logic [A:0]      r_wptr;
   logic [c_GW-1:0] r_rr_ptr;
   logic            r_full;
   logic            r_afull;

   logic            w_arb_en;
   logic [A:0]      w_wbin_next;
   logic [A:0]      w_gray_next;
   logic [A:0]      w_rbin;
   logic [A:0]      w_count_next;
   logic [A:0]      w_rptr_full;

   // Grant depends only on registered state and req_valid, so no loop through req_ready.
   assign w_arb_en = ~r_full & ~w_Rst;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .GW      (c_GW)
   ) u_rr_arbiter (
      .req      (req_valid),
      .en       (w_arb_en),
      .rr_ptr   (r_rr_ptr),
      .grant    (req_ready),
      .grant_id (grant_id)
   );

   assign w_En   = |(req_valid & req_ready);
   assign w_Addr = r_wbin[A-1:0];
   assign w_Data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

   assign w_wbin_next  = r_wbin + (A+1)'(w_En);
   assign w_gray_next  = (A+1)'(bin2gray(32'(w_wbin_next), A+1));
   assign w_rbin       = (A+1)'(gray2bin(32'(wsync_Rptr), A+1));
   assign w_count_next = w_wbin_next - w_rbin;
   // Full when write pointer is one lap ahead: top two Gray bits inverted.
   assign w_rptr_full  = {~wsync_Rptr[A:A-1], wsync_Rptr[A-2:0]};

   always_ff @(posedge w_Clk) begin
      if (w_Rst) begin
         r_wbin   <= '0;
         r_wptr   <= '0;
         r_rr_ptr <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
      end else begin
         if (w_En) begin
            r_wbin   <= w_wbin_next;
            r_wptr   <= w_gray_next;
            r_rr_ptr <= (grant_id == c_LAST_REQ) ? '0 : grant_id + 1'b1;
         end
         r_full  <= (w_gray_next == w_rptr_full);
         r_afull <= (w_count_next >= c_AFULL_LVL);
      end
   end

   assign w_Ptr        = r_wptr;
   assign w_Full       = r_full;
   assign w_AlmostFull = r_afull;

endmodule

`default_nettype wire
